// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the request error check for the load/store unit.
// Pure declarations: no latency and no flow-control behaviour of its own.
package lsu_pkg;

    localparam int unsigned LSU_MEM_WORDS = 64;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } lsu_state_t;

    // Misaligned half/word, the reserved size code, or a word index past the memory.
    function automatic logic lsu_req_err(input logic [1:0] size, input logic [31:0] addr,
                                         input int unsigned words);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr[0];
            SIZE_WORD: err = (addr[1:0] != 2'b00);
            default:   err = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= words) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extract with sign/zero extension for loads, lane merge for stores.
// Purely combinational, zero latency; no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = mem_word[8*offset +: 8];
        half_lane = offset[1] ? mem_word[31:16] : mem_word[15:0];

        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:   load_data = mem_word;
        endcase

        merged_word = mem_word;
        case (size)
            SIZE_BYTE: merged_word[8*offset +: 8] = store_data[7:0];
            SIZE_HALF: begin
                if (offset[1]) begin
                    merged_word[31:16] = store_data[15:0];
                end else begin
                    merged_word[15:0] = store_data[15:0];
                end
            end
            default:   merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time data-memory initiator; sub-word stores are read-modify-write on a word memory.
// Response after 1 (error) / 2 (word store) / 3 (load) / 4 (sub-word store) edges; req_ready low while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        memWrite,
    output logic        memRead,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    lsu_state_t  state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;

    lsu_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .mem_word    (readData),
        .store_data  (data_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d   = req_write;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    addr_d = req_addr;
                    data_d = req_wdata;
                    if (lsu_req_err(req_size, req_addr, MEM_WORDS)) begin
                        resp_rdata_d = '0;
                        resp_error_d = 1'b1;
                        state_d      = S_RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                // data_q is reused to carry the merged word into WRITE.
                if (wr_q) begin
                    data_d  = merged_word;
                    state_d = S_WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    resp_error_d = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                resp_rdata_d = '0;
                resp_error_d = 1'b0;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = resp_rdata_q;
        resp_error = resp_error_q;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        address    = '0;
        writeData  = '0;
        case (state_q)
            S_READ: begin
                memRead = 1'b1;
                address = {2'b00, addr_q[31:2]};
            end
            S_WRITE: begin
                memWrite  = 1'b1;
                address   = {2'b00, addr_q[31:2]};
                writeData = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural 64-word data memory.
// Each task drives its own scenario and checks latency, data, errors and strobes inline.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        memWrite;
    logic        memRead;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    int          wr_count = 0;
    int          rd_count = 0;
    logic        both_hi = 1'b0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (memWrite) begin
            mem[address[5:0]] <= writeData;
            wr_count          <= wr_count + 1;
            last_wr_addr      <= address;
            last_wr_data      <= writeData;
        end
        if (memRead) begin
            readData <= mem[address[5:0]];
            rd_count <= rd_count + 1;
        end
        if (memRead && memWrite) begin
            both_hi <= 1'b1;
        end
    end

    // Issue one request when idle; lat counts edges from accept to the resp_valid cycle.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                er  = resp_error;
                break;
            end
        end
        if (lat == 0) lat = 99;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if ({memRead, memWrite} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {memRead, memWrite}); end
        checks++; if (address !== 32'h0 || writeData !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h %h exp 0 0", address, writeData); end
        checks++; if (resp_rdata !== 32'h0 || resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp got %h %b exp 0 0", resp_rdata, resp_error); end
        reset = 1'b1;
    endtask

    task automatic test_word_store_load();
        int lat; logic [31:0] rd; logic er; int w0; int r0;
        w0 = wr_count; r0 = rd_count;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_latency got %0d exp 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store_resp got %h %b exp 0 0", rd, er); end
        checks++; if (wr_count - w0 !== 1 || rd_count !== r0) begin errors++; $display("FAIL word_store_strobes got wr %0d rd %0d exp 1 0", wr_count - w0, rd_count - r0); end
        checks++; if (last_wr_addr !== 32'd4 || last_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_bus got %h %h exp 4 deadbeef", last_wr_addr, last_wr_data); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL word_load_data got %h %b exp deadbeef 0", rd, er); end
    endtask

    task automatic test_sub_word_store();
        int lat; logic [31:0] rd; logic er; int r0;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, er);
        r0 = rd_count;
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, lat, rd, er);
        checks++; if (lat !== 4) begin errors++; $display("FAIL byte_store_latency got %0d exp 4", lat); end
        checks++; if (rd_count - r0 !== 1) begin errors++; $display("FAIL byte_store_read got %0d exp 1", rd_count - r0); end
        checks++; if (last_wr_addr !== 32'd4 || last_wr_data !== 32'h11AA3344) begin errors++; $display("FAIL byte_store_merge got %h %h exp 4 11aa3344", last_wr_addr, last_wr_data); end
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h8000F0FF, lat, rd, er);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hABCD1234, lat, rd, er);
        checks++; if (lat !== 4 || last_wr_data !== 32'h1234F0FF) begin errors++; $display("FAIL half_store_merge got %0d %h exp 4 1234f0ff", lat, last_wr_data); end
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h8000F0FF, lat, rd, er);
    endtask

    task automatic test_sub_word_loads();
        logic [1:0]  sz  [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic        un  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ad  [7] = '{32'h14, 32'h16, 32'h16, 32'h15, 32'h17, 32'h14, 32'h12};
        logic [31:0] exp [7] = '{32'hFFFFFFFF, 32'h00008000, 32'hFFFF8000, 32'h000000F0,
                                 32'hFFFFFF80, 32'h0000F0FF, 32'h000000AA};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er);
            checks++;
            if (rd !== exp[i] || er !== 1'b0 || lat !== 3) begin
                errors++;
                $display("FAIL subword_load_%0d got %h err %b lat %0d exp %h err 0 lat 3", i, rd, er, lat, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [31:0] ad [4] = '{32'h13, 32'h11, 32'h100, 32'h0};
        int lat; logic [31:0] rd; logic er; int w0; int r0;
        w0 = wr_count; r0 = rd_count;
        for (int i = 0; i < 4; i++) begin
            do_req(wr[i], sz[i], 1'b0, ad[i], 32'h12345678, lat, rd, er);
            checks++;
            if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL error_case_%0d got err %b lat %0d rd %h exp 1 1 0", i, er, lat, rd);
            end
        end
        checks++; if (wr_count !== w0 || rd_count !== r0) begin errors++; $display("FAIL error_no_access got wr %0d rd %0d exp 0 0", wr_count - w0, rd_count - r0); end
        do_req(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, lat, rd, er);
        checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL last_index_ok got err %b lat %0d exp 0 3", er, lat); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [31:0] rd; logic er; int w0; logic seen;
        do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788, lat, rd, er);
        w0 = wr_count;
        @(negedge clock);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h18; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        #1;
        checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL rmw_read_start got %b exp 1", memRead); end
        reset = 1'b0;
        #1;
        checks++; if ({memRead, memWrite} !== 2'b00) begin errors++; $display("FAIL async_reset_strobes got %b exp 00", {memRead, memWrite}); end
        seen = 1'b0;
        repeat (3) begin @(negedge clock); if (resp_valid) seen = 1'b1; end
        reset = 1'b1;
        repeat (5) begin @(negedge clock); if (resp_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_resp got %b exp 0", seen); end
        checks++; if (req_ready !== 1'b1 || wr_count !== w0) begin errors++; $display("FAIL reset_recover got ready %b writes %0d exp 1 0", req_ready, wr_count - w0); end
        do_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL reset_mem_intact got %h exp 55667788", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic busy_ready; logic seen_resp;
        @(negedge clock);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h1C; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_write = 1'b0; req_wdata = 32'h0;
        busy_ready = 1'b0; seen_resp = 1'b0; lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (req_ready) busy_ready = 1'b1;
            if (resp_valid) begin lat = i; seen_resp = 1'b1; break; end
        end
        checks++; if (lat !== 2 || busy_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got lat %0d ready_while_busy %b exp 2 0", lat, busy_ready); end
        @(negedge clock);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble got ready %b resp %b exp 1 0", req_ready, resp_valid); end
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (resp_valid) begin lat = i; break; end
        end
        checks++; if (lat !== 3 || resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_second got lat %0d rd %h exp 3 cafef00d", lat, resp_rdata); end
        checks++; if (both_hi !== 1'b0) begin errors++; $display("FAIL strobes_exclusive got %b exp 0", both_hi); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_word_store_load();
        test_sub_word_store();
        test_sub_word_loads();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
